// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle MIPS control unit (Moore FSM with memory wait states)
//
// Purpose:
//   Sequences fetch, decode, execute, memory and writeback for the multicycle
//   MIPS datapath and drives every datapath control strobe. Memory accesses
//   are stretched by MEM_WAIT wait cycles (0..7). Unsupported opcodes or
//   R-type function codes park the unit in HALT until Reset.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high
//   Op[5:0]      in   instruction bits 31:26
//   Funct[5:0]   in   instruction bits 5:0
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified by ULA zero outside this block
//   IorD         out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite     out  memory write strobe
//   MemtoReg     out  register write data select (0 = ALUOut, 1 = MDR)
//   IRWrite      out  instruction register load
//   MDRLoad      out  MDR load
//   ALoad        out  A register load
//   BLoad        out  B register load
//   ALUOutLoad   out  ALUOut register load
//   PCSource     out  PC input select (00 ULA, 01 ALUOut, 10 jump target)
//   ALUOp        out  Ula32 selector (000 A, 001 add, 010 sub, 011 and, 110 xor)
//   ALUSrcA      out  ULA A select (0 = PC, 1 = A)
//   ALUSrcB      out  ULA B select (00 B, 01 4, 10 imm, 11 imm << 2)
//   RegWrite     out  register bank write
//   RegDst       out  destination select (0 = rt, 1 = rd)
//   Estado       out  current state code, debug only
//   Halted       out  high while in HALT

module uc_multiciclo #(
  parameter int MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MDRLoad,
  output logic       ALoad,
  output logic       BLoad,
  output logic       ALUOutLoad,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [4:0] Estado,
  output logic       Halted
);

  typedef enum logic [4:0] {
    S_RST        = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_R_EXEC     = 5'd5,
    S_R_WB       = 5'd6,
    S_MEM_ADDR   = 5'd7,
    S_LW_WAIT    = 5'd8,
    S_LW_MDR     = 5'd9,
    S_LW_WB      = 5'd10,
    S_SW_WR      = 5'd11,
    S_BRANCH     = 5'd12,
    S_JUMP       = 5'd13,
    S_ADDI_EXEC  = 5'd14,
    S_ADDI_WB    = 5'd15,
    S_HALT       = 5'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b110;

  // Last counter value of a wait phase; unused when MEM_WAIT is 0.
  localparam logic [2:0] LP_WAIT_LAST = 3'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_wait_cnt;
  logic       r_is_lw;
  logic       w_wait_done;
  logic [2:0] w_r_aluop;
  logic       w_r_legal;

  // With no wait states a LW_WAIT visit still lasts exactly one cycle.
  assign w_wait_done = (MEM_WAIT == 0) || (r_wait_cnt == LP_WAIT_LAST);

  // Load/store direction is captured in DECODE so MEM_ADDR does not depend
  // on Op, which the instruction register may no longer hold steady.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_RST;
      r_wait_cnt <= 3'd0;
      r_is_lw    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_lw <= (Op == OP_LW);
      end
      if ((r_state == S_FETCH_WAIT) || (r_state == S_LW_WAIT)) begin
        if (w_wait_done) begin
          r_wait_cnt <= 3'd0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 3'd1;
        end
      end else begin
        r_wait_cnt <= 3'd0;
      end
    end
  end

  always_comb begin
    w_r_aluop = ALU_PASS;
    w_r_legal = 1'b1;
    case (Funct)
      FN_ADD:  w_r_aluop = ALU_ADD;
      FN_SUB:  w_r_aluop = ALU_SUB;
      FN_AND:  w_r_aluop = ALU_AND;
      FN_XOR:  w_r_aluop = ALU_XOR;
      default: w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    MDRLoad     = 1'b0;
    ALoad       = 1'b0;
    BLoad       = 1'b0;
    ALUOutLoad  = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = ALU_PASS;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    Halted      = 1'b0;

    case (r_state)
      S_RST: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        IorD   = 1'b0;
        w_next = (MEM_WAIT == 0) ? S_IR_LOAD : S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IorD = 1'b0;
        if (w_wait_done) begin
          w_next = S_IR_LOAD;
        end
      end
      S_IR_LOAD: begin
        IorD     = 1'b0;
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b01;
        ALUOp    = ALU_ADD;
        w_next   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ALoad      = 1'b1;
        BLoad      = 1'b1;
        ALUOutLoad = 1'b1;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b11;
        ALUOp      = ALU_ADD;
        case (Op)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_HALT;
        endcase
      end
      S_R_EXEC: begin
        // ALUOut is loaded even for an illegal Funct; the register bank is
        // never written because the write-back state is skipped.
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b00;
        ALUOutLoad = 1'b1;
        ALUOp      = w_r_aluop;
        w_next     = w_r_legal ? S_R_WB : S_HALT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = 1'b0;
        w_next   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_ADD;
        ALUOutLoad = 1'b1;
        w_next     = r_is_lw ? S_LW_WAIT : S_SW_WR;
      end
      S_LW_WAIT: begin
        IorD = 1'b1;
        if (w_wait_done) begin
          w_next = S_LW_MDR;
        end
      end
      S_LW_MDR: begin
        IorD    = 1'b1;
        MDRLoad = 1'b1;
        w_next  = S_LW_WB;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b0;
        MemtoReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_ADD;
        ALUOutLoad = 1'b1;
        w_next     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        // Unreachable encodings are treated like an unsupported opcode.
        w_next = S_HALT;
      end
    endcase
  end

  assign Estado = Reset ? 5'd0 : r_state;

endmodule
